// File: rtl/nes_joypad_pkg.sv
// Shared joypad definitions: report button bit positions and shift register geometry.
// Used by the report decoders and by the NES controller port emulation.
package nes_joypad_pkg;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_idx_e;

    localparam int unsigned BTN_COUNT = 32'd8;
    localparam logic [3:0]  CNT_FULL  = 4'd8;

    // Shift counter step that sticks once all button bits are out.
    function automatic logic [3:0] cnt_step(input logic [3:0] cnt);
        if (cnt == CNT_FULL) begin
            return cnt;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

endpackage

// File: rtl/nes_joypad_shifter.sv
// One controller pad: 4021-style parallel-load shift register with read-edge
// detection, saturating shift counter and registered serial/empty outputs.
module nes_joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter logic C_FILL_BIT = 1'b1,
    parameter int   C_RD_EDGE  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [BTN_COUNT-1:0] i_btn,
    input  logic                 i_rd,
    output logic                 o_data,
    output logic                 o_empty
);

    logic [BTN_COUNT-1:0] sr_r;
    logic [BTN_COUNT-1:0] sr_nxt_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_nxt_s;
    logic                 rd_d_r;
    logic                 arm_r;
    logic                 rd_edge_s;
    logic                 data_r;
    logic                 empty_r;

    // Read-edge detect; arm_r masks the first cycle after reset so a strobe
    // already high at release is never mistaken for an edge.
    always_comb begin
        rd_edge_s = 1'b0;
        if (C_RD_EDGE != 32'sd0) begin
            rd_edge_s = arm_r & i_rd & ~rd_d_r;
        end else begin
            rd_edge_s = arm_r & ~i_rd & rd_d_r;
        end
    end

    // Next shift state: parallel load beats any coincident read edge.
    always_comb begin
        sr_nxt_s  = sr_r;
        cnt_nxt_s = cnt_r;
        if (i_load) begin
            sr_nxt_s  = i_btn;
            cnt_nxt_s = 4'd0;
        end else if (rd_edge_s) begin
            sr_nxt_s  = {C_FILL_BIT, sr_r[BTN_RIGHT:1]};
            cnt_nxt_s = cnt_step(cnt_r);
        end else begin
            sr_nxt_s  = sr_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Pad state and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr_r    <= '0;
            cnt_r   <= 4'd0;
            rd_d_r  <= 1'b0;
            arm_r   <= 1'b0;
            data_r  <= 1'b0;
            empty_r <= 1'b0;
        end else begin
            sr_r    <= sr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rd_d_r  <= i_rd;
            arm_r   <= 1'b1;
            data_r  <= sr_nxt_s[BTN_A];
            empty_r <= (cnt_nxt_s == CNT_FULL);
        end
    end

    assign o_data  = data_r;
    assign o_empty = empty_r;

endmodule

// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 controller port emulation: shared strobe latch driving two
// independent pad shifters fed from live USB-derived button state.
module nes_joypad_port
    import nes_joypad_pkg::*;
#(
    parameter logic C_FILL_BIT = 1'b1,
    parameter int   C_RD_EDGE  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BTN_COUNT-1:0] i_btn0,
    input  logic [BTN_COUNT-1:0] i_btn1,
    input  logic                 i_wr,
    input  logic                 i_wr_data,
    input  logic                 i_rd0,
    input  logic                 i_rd1,
    output logic                 o_data0,
    output logic                 o_data1,
    output logic                 o_empty0,
    output logic                 o_empty1
);

    logic strobe_r;
    logic load_s;

    // Strobe latch written through $4016 bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            strobe_r <= 1'b0;
        end else if (i_wr) begin
            strobe_r <= i_wr_data;
        end else begin
            strobe_r <= strobe_r;
        end
    end

    // The write cycle itself also loads, so a 1->0 strobe never loses a sample.
    assign load_s = strobe_r | i_wr;

    nes_joypad_shifter #(
        .C_FILL_BIT (C_FILL_BIT),
        .C_RD_EDGE  (C_RD_EDGE)
    ) u_pad0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load_s),
        .i_btn   (i_btn0),
        .i_rd    (i_rd0),
        .o_data  (o_data0),
        .o_empty (o_empty0)
    );

    nes_joypad_shifter #(
        .C_FILL_BIT (C_FILL_BIT),
        .C_RD_EDGE  (C_RD_EDGE)
    ) u_pad1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load_s),
        .i_btn   (i_btn1),
        .i_rd    (i_rd1),
        .o_data  (o_data1),
        .o_empty (o_empty1)
    );

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: stimulus queues expected
// {data0,data1,empty0,empty1}; a negedge monitor pops and compares.
module tb_nes_joypad_port;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_btn0 = 8'h00;
    logic [7:0] i_btn1 = 8'h00;
    logic       i_wr = 1'b0;
    logic       i_wr_data = 1'b0;
    logic       i_rd0 = 1'b0;
    logic       i_rd1 = 1'b0;
    logic       o_data0;
    logic       o_data1;
    logic       o_empty0;
    logic       o_empty1;

    int checks = 0;
    int errors = 0;

    string      q_name[$];
    logic [3:0] q_exp[$];

    // Reference model: button pattern captured at load and shifts seen since.
    logic [7:0] pat0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    int         n0 = 0;
    int         n1 = 0;

    nes_joypad_port dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_btn0    (i_btn0),
        .i_btn1    (i_btn1),
        .i_wr      (i_wr),
        .i_wr_data (i_wr_data),
        .i_rd0     (i_rd0),
        .i_rd1     (i_rd1),
        .o_data0   (o_data0),
        .o_data1   (o_data1),
        .o_empty0  (o_empty0),
        .o_empty1  (o_empty1)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic exp_bit(input logic [7:0] pat, input int n);
        if (n < 8) return pat[n];
        else       return 1'b1;
    endfunction

    function automatic logic exp_empty(input int n);
        return (n >= 8) ? 1'b1 : 1'b0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic [3:0] e);
        q_name.push_back(name);
        q_exp.push_back(e);
    endtask

    task automatic expect_model(input string name);
        expect_all(name, {exp_bit(pat0, n0), exp_bit(pat1, n1), exp_empty(n0), exp_empty(n1)});
    endtask

    task automatic write(input logic v);
        i_wr = 1'b1;
        i_wr_data = v;
        cyc(1);
        i_wr = 1'b0;
        pat0 = i_btn0;
        pat1 = i_btn1;
        n0 = 0;
        n1 = 0;
    endtask

    task automatic load_pads(input string name);
        write(1'b1);
        write(1'b0);
        expect_model(name);
    endtask

    task automatic pulse(input string name, input logic r0, input logic r1);
        i_rd0 = r0;
        i_rd1 = r1;
        cyc(1);
        expect_model({name, "_hi"});
        i_rd0 = 1'b0;
        i_rd1 = 1'b0;
        cyc(1);
        if (r0) n0++;
        if (r1) n1++;
        expect_model(name);
    endtask

    // Monitor: compare every queued expectation against the outputs.
    always @(negedge i_clk) begin
        while (q_exp.size() > 0) begin
            string      nm;
            logic [3:0] ex;
            logic [3:0] act;
            nm  = q_name.pop_front();
            ex  = q_exp.pop_front();
            act = {o_data0, o_data1, o_empty0, o_empty1};
            checks++;
            if (act !== ex) begin
                errors++;
                $display("FAIL %s got d0d1e0e1=%b want %b at %0t", nm, act, ex, $time);
            end
        end
    end

    initial begin
        // Reset: strobe write and buttons present must not leak through.
        i_btn0 = 8'hFF;
        i_btn1 = 8'hFF;
        i_wr = 1'b1;
        i_wr_data = 1'b1;
        cyc(2);
        expect_all("reset_hold", 4'b0000);
        cyc(1);
        expect_all("reset_hold2", 4'b0000);
        i_wr = 1'b0;
        i_rst = 1'b0;
        cyc(1);
        expect_model("reset_release");

        // Scenario 1: A5 through 9 read pulses.
        i_btn0 = 8'hA5;
        i_btn1 = 8'h3C;
        load_pads("s1_load");
        for (int i = 0; i < 9; i++) pulse("s1_pulse", 1'b1, 1'b0);

        // Scenario 2: held read strobe gives one shift on its falling edge.
        load_pads("s2_load");
        i_rd0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            expect_model("s2_held");
        end
        i_rd0 = 1'b0;
        cyc(1);
        n0++;
        expect_model("s2_fall");
        cyc(1);
        expect_model("s2_after1");
        cyc(1);
        expect_model("s2_after2");

        // Scenario 3: strobe high, pad1 bit0 toggles, reads ignored.
        i_btn1 = 8'h00;
        write(1'b1);
        for (int i = 0; i < 6; i++) begin
            i_btn1[0] = i[0];
            i_rd1 = i[1];
            cyc(1);
            expect_all("s3_track", {i_btn0[0], i_btn1[0], 2'b00});
        end
        i_rd1 = 1'b0;
        cyc(1);
        expect_all("s3_track_end", {i_btn0[0], i_btn1[0], 2'b00});
        i_btn1 = 8'h3C;
        write(1'b0);
        expect_model("s3_release");
        for (int i = 0; i < 8; i++) pulse("s3_count", 1'b0, 1'b1);

        // Scenario 4: write coinciding with a falling read edge.
        i_btn0 = 8'hA5;
        load_pads("s4_load");
        i_rd0 = 1'b1;
        cyc(1);
        expect_model("s4_rd_hi");
        i_rd0 = 1'b0;
        i_btn0 = 8'hC3;
        i_wr = 1'b1;
        i_wr_data = 1'b0;
        cyc(1);
        i_wr = 1'b0;
        pat0 = i_btn0;
        pat1 = i_btn1;
        n0 = 0;
        n1 = 0;
        expect_model("s4_load_wins");
        for (int i = 0; i < 8; i++) pulse("s4_count", 1'b1, 1'b0);

        // Scenario 5: reset after 3 shifts with the read strobe held high.
        i_btn0 = 8'hA5;
        load_pads("s5_load");
        for (int i = 0; i < 3; i++) pulse("s5_pre", 1'b1, 1'b0);
        i_rd0 = 1'b1;
        cyc(1);
        expect_model("s5_rd_hi");
        i_rst = 1'b1;
        cyc(1);
        expect_all("s5_rst", 4'b0000);
        cyc(1);
        expect_all("s5_rst2", 4'b0000);
        i_rst = 1'b0;
        cyc(1);
        pat0 = 8'h00;
        pat1 = 8'h00;
        n0 = 0;
        n1 = 0;
        expect_model("s5_release");
        cyc(1);
        expect_model("s5_still_hi");
        i_rd0 = 1'b0;
        cyc(1);
        n0++;
        expect_model("s5_new_edge");
        for (int i = 0; i < 7; i++) pulse("s5_fill", 1'b1, 1'b0);

        // Scenario 6: simultaneous reads on both pads.
        i_btn0 = 8'h01;
        i_btn1 = 8'h02;
        load_pads("s6_load");
        pulse("s6_both", 1'b1, 1'b1);

        cyc(2);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
